// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: elastic pipeline-stage register carrying pc/instr/O/D/E.
// A main entry drives the outputs; with SKID=1 a second (skid) entry absorbs
// the payload that was already in flight when the downstream stalled.
//
// Handshake: a payload moves on a rising edge only when its valid and ready
// are both high in that cycle (accept = in_valid & in_ready, pop = out_valid &
// out_ready). valid never depends on ready. Once out_valid is high the output
// payload does not change until it is popped or flushed.
module reg_pipe_stage #(
   parameter int unsigned        PC_W      = 32,
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        DATA_W    = 32,
   parameter int unsigned        EXC_W     = 3,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter bit                 SKID      = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [DATA_W-1:0]  O_in,
   input  logic [DATA_W-1:0]  D_in,
   input  logic [EXC_W-1:0]   E_in,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instr_out,
   output logic [DATA_W-1:0]  O_out,
   output logic [DATA_W-1:0]  D_out,
   output logic [EXC_W-1:0]   E_out,
   output logic [1:0]         occupancy
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [DATA_W-1:0]  o;
      logic [DATA_W-1:0]  d;
      logic [EXC_W-1:0]   e;
   } payload_t;

   payload_t main_q, main_d;
   payload_t skid_q, skid_d;
   payload_t in_pl;
   logic     main_v_q, main_v_d;
   logic     skid_v_q, skid_v_d;
   // Low during reset and for the release edge so in_ready stays 0 until the
   // stage has seen one clean clock.
   logic     alive_q;
   logic     accept;
   logic     pop;

   assign in_pl = '{pc: pc_in, instr: instr_in, o: O_in, d: D_in, e: E_in};

   // With a skid entry, ready comes purely from registered state; without
   // one, a pop in the same cycle frees the single entry.
   assign in_ready = SKID ? (alive_q & ~skid_v_q)
                          : (alive_q & (~main_v_q | out_ready));

   assign accept = in_valid & in_ready;
   assign pop    = main_v_q & out_ready;

   // Next-state: pop first, then refill main from skid, then place the
   // incoming payload in the first free slot so ordering stays FIFO.
   always_comb begin
      main_d   = main_q;
      skid_d   = skid_q;
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else begin
         if (pop) begin
            main_v_d = 1'b0;
         end
         if (pop && skid_v_q) begin
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
         end
         if (accept) begin
            if (!main_v_d) begin
               main_d   = in_pl;
               main_v_d = 1'b1;
            end else if (SKID) begin
               skid_d   = in_pl;
               skid_v_d = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         main_q   <= '{pc: '0, instr: NOP_INSTR, o: '0, d: '0, e: '0};
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         alive_q  <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         alive_q  <= 1'b1;
      end
   end

   // A bubble shows NOP and no exception; pc/O/D keep the last payload.
   assign out_valid = main_v_q;
   assign pc_out    = main_q.pc;
   assign O_out     = main_q.o;
   assign D_out     = main_q.d;
   assign instr_out = main_v_q ? main_q.instr : NOP_INSTR;
   assign E_out     = main_v_q ? main_q.e : '0;
   assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_reg_pipe_stage.sv
// Directed bench for reg_pipe_stage: one SKID=1 and one SKID=0 instance on a
// shared clock/reset, expected values written out by hand per vector.
module tb_reg_pipe_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clock = 1'b0;
   logic reset = 1'b0;

   // SKID=1 instance signals
   logic        s1_in_valid, s1_in_ready, s1_flush, s1_out_valid, s1_out_ready;
   logic [31:0] s1_pc_in, s1_instr_in, s1_o_in, s1_d_in;
   logic [2:0]  s1_e_in;
   logic [31:0] s1_pc_out, s1_instr_out, s1_o_out, s1_d_out;
   logic [2:0]  s1_e_out;
   logic [1:0]  s1_occ;

   // SKID=0 instance signals
   logic        s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready;
   logic [31:0] s0_pc_in, s0_instr_in, s0_o_in, s0_d_in;
   logic [2:0]  s0_e_in;
   logic [31:0] s0_pc_out, s0_instr_out, s0_o_out, s0_d_out;
   logic [2:0]  s0_e_out;
   logic [1:0]  s0_occ;

   int n_checks = 0;
   int n_fail   = 0;

   reg_pipe_stage #(.NOP_INSTR(NOP), .SKID(1'b1)) u_skid1 (
      .clock(clock), .reset(reset),
      .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .pc_in(s1_pc_in), .instr_in(s1_instr_in), .O_in(s1_o_in), .D_in(s1_d_in), .E_in(s1_e_in),
      .flush(s1_flush), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
      .pc_out(s1_pc_out), .instr_out(s1_instr_out), .O_out(s1_o_out), .D_out(s1_d_out),
      .E_out(s1_e_out), .occupancy(s1_occ)
   );

   reg_pipe_stage #(.NOP_INSTR(NOP), .SKID(1'b0)) u_skid0 (
      .clock(clock), .reset(reset),
      .in_valid(s0_in_valid), .in_ready(s0_in_ready),
      .pc_in(s0_pc_in), .instr_in(s0_instr_in), .O_in(s0_o_in), .D_in(s0_d_in), .E_in(s0_e_in),
      .flush(s0_flush), .out_valid(s0_out_valid), .out_ready(s0_out_ready),
      .pc_out(s0_pc_out), .instr_out(s0_instr_out), .O_out(s0_o_out), .D_out(s0_d_out),
      .E_out(s0_e_out), .occupancy(s0_occ)
   );

   // clock / reset
   always #5 clock = ~clock;

   // instr derived from pc so payload integrity is visible on instr_out too
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // registered outputs settle #1 after the rising edge; inputs change there too
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [31:0] pc, input logic [2:0] e,
                         input logic rdy, input logic fl);
      s1_in_valid  = v;
      s1_pc_in     = pc;
      s1_instr_in  = instr_of(pc);
      s1_o_in      = pc + 32'd1;
      s1_d_in      = pc + 32'd2;
      s1_e_in      = e;
      s1_out_ready = rdy;
      s1_flush     = fl;
   endtask

   task automatic drive0(input logic v, input logic [31:0] pc, input logic rdy);
      s0_in_valid  = v;
      s0_pc_in     = pc;
      s0_instr_in  = instr_of(pc);
      s0_o_in      = pc + 32'd1;
      s0_d_in      = pc + 32'd2;
      s0_e_in      = 3'd0;
      s0_out_ready = rdy;
      s0_flush     = 1'b0;
   endtask

   // SKID=0 vector table: out_ready, offered pc, expected comb in_ready,
   // expected pc_out after the edge
   logic        t_rdy [7];
   logic [31:0] t_pc  [7];
   logic        t_irdy[7];
   logic [31:0] t_pco [7];
   logic        t_ov  [7];

   initial begin
      drive1(1'b1, 32'hDEAD, 3'd0, 1'b0, 1'b0);
      drive0(1'b1, 32'hBEEF, 1'b0);

      // 1: reset held two cycles with in_valid high
      reset = 1'b0;
      tick();
      tick();
      check_eq("rst_out_valid", 64'(s1_out_valid), 64'd0);
      check_eq("rst_instr_nop", 64'(s1_instr_out), 64'(NOP));
      check_eq("rst_in_ready",  64'(s1_in_ready), 64'd0);
      check_eq("rst_pc_zero",   64'(s1_pc_out), 64'd0);
      check_eq("rst_e_zero",    64'(s1_e_out), 64'd0);
      check_eq("rst_s0_ready",  64'(s0_in_ready), 64'd0);
      drive1(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      drive0(1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      tick();
      check_eq("rel_in_ready",  64'(s1_in_ready), 64'd1);
      check_eq("rel_occ",       64'(s1_occ), 64'd0);
      check_eq("rel_out_valid", 64'(s1_out_valid), 64'd0);

      // 2: streaming, one-cycle latency, back-to-back
      drive1(1'b1, 32'h100, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("st_pc100",    64'(s1_pc_out), 64'h100);
      check_eq("st_instr100", 64'(s1_instr_out), 64'(32'h100 ^ 32'hA5A5_0000));
      check_eq("st_o100",     64'(s1_o_out), 64'h101);
      check_eq("st_d100",     64'(s1_d_out), 64'h102);
      check_eq("st_occ1",     64'(s1_occ), 64'd1);
      drive1(1'b1, 32'h104, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("st_pc104", 64'(s1_pc_out), 64'h104);
      check_eq("st_v104",  64'(s1_out_valid), 64'd1);
      drive1(1'b1, 32'h108, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("st_pc108", 64'(s1_pc_out), 64'h108);
      check_eq("st_occ1b", 64'(s1_occ), 64'd1);
      drive1(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("st_drain_v",   64'(s1_out_valid), 64'd0);
      check_eq("st_drain_nop", 64'(s1_instr_out), 64'(NOP));
      check_eq("st_pc_hold",   64'(s1_pc_out), 64'h108);

      // 3: back-pressure fills main then skid, then drains in order
      drive1(1'b1, 32'h200, 3'd0, 1'b0, 1'b0);
      tick();
      check_eq("bp_occ1",  64'(s1_occ), 64'd1);
      check_eq("bp_rdy1",  64'(s1_in_ready), 64'd1);
      drive1(1'b1, 32'h204, 3'd0, 1'b0, 1'b0);
      tick();
      check_eq("bp_occ2",  64'(s1_occ), 64'd2);
      check_eq("bp_rdy0",  64'(s1_in_ready), 64'd0);
      check_eq("bp_pc200", 64'(s1_pc_out), 64'h200);
      drive1(1'b1, 32'h208, 3'd0, 1'b0, 1'b0);
      tick();
      check_eq("bp_hold_pc",  64'(s1_pc_out), 64'h200);
      check_eq("bp_hold_occ", 64'(s1_occ), 64'd2);
      drive1(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("bp_pc204",   64'(s1_pc_out), 64'h204);
      check_eq("bp_instr204", 64'(s1_instr_out), 64'(32'h204 ^ 32'hA5A5_0000));
      check_eq("bp_occ_dn",  64'(s1_occ), 64'd1);
      check_eq("bp_rdy_up",  64'(s1_in_ready), 64'd1);
      tick();
      check_eq("bp_empty_v", 64'(s1_out_valid), 64'd0);
      check_eq("bp_empty_o", 64'(s1_occ), 64'd0);

      // 4: flush with both entries full and an offer pending
      drive1(1'b1, 32'h2A0, 3'b011, 1'b0, 1'b0);
      tick();
      drive1(1'b1, 32'h2A4, 3'b011, 1'b0, 1'b0);
      tick();
      check_eq("fl_pre_occ", 64'(s1_occ), 64'd2);
      check_eq("fl_pre_e",   64'(s1_e_out), 64'b011);
      drive1(1'b1, 32'h300, 3'b011, 1'b0, 1'b1);
      tick();
      check_eq("fl_v",     64'(s1_out_valid), 64'd0);
      check_eq("fl_e",     64'(s1_e_out), 64'd0);
      check_eq("fl_nop",   64'(s1_instr_out), 64'(NOP));
      check_eq("fl_occ",   64'(s1_occ), 64'd0);
      check_eq("fl_rdy",   64'(s1_in_ready), 64'd1);
      drive1(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("fl_no300", 64'(s1_out_valid), 64'd0);
      // flush wins over an accept when the stage is empty and ready
      drive1(1'b1, 32'h304, 3'd0, 1'b1, 1'b1);
      #1;
      check_eq("fl2_rdy",  64'(s1_in_ready), 64'd1);
      tick();
      check_eq("fl2_v",    64'(s1_out_valid), 64'd0);
      check_eq("fl2_occ",  64'(s1_occ), 64'd0);
      drive1(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("fl2_no304", 64'(s1_out_valid), 64'd0);

      // 5: exception code carried unaltered, cleared on bubble
      drive1(1'b1, 32'h40, 3'b101, 1'b1, 1'b0);
      tick();
      check_eq("ex_e",  64'(s1_e_out), 64'b101);
      check_eq("ex_pc", 64'(s1_pc_out), 64'h40);
      drive1(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      tick();
      check_eq("ex_bub_e",  64'(s1_e_out), 64'd0);
      check_eq("ex_bub_pc", 64'(s1_pc_out), 64'h40);

      // 6: SKID=0, out_ready toggling with in_valid held high
      t_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      t_pc   = '{32'h500, 32'h504, 32'h504, 32'h508, 32'h508, 32'h50C, 32'h50C};
      t_irdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      t_pco  = '{32'h500, 32'h500, 32'h504, 32'h504, 32'h508, 32'h508, 32'h508};
      t_ov   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         // last vector only drains: nothing offered
         drive0(i < 6, t_pc[i], t_rdy[i]);
         #1;
         check_eq($sformatf("s0_rdy[%0d]", i), 64'(s0_in_ready), 64'(t_irdy[i]));
         tick();
         check_eq($sformatf("s0_v[%0d]", i), 64'(s0_out_valid), 64'(t_ov[i]));
         check_eq($sformatf("s0_pc[%0d]", i), 64'(s0_pc_out), 64'(t_pco[i]));
      end
      check_eq("s0_occ_end", 64'(s0_occ), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
